// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS serializer: symbol width, control tokens and clock lane pattern.
package tmds_pkg;

  localparam int unsigned WORD_W = 10;

  localparam logic [WORD_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [WORD_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [WORD_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [WORD_W-1:0] CTRL_11 = 10'b1010101011;

  localparam logic [WORD_W-1:0] CLK_PATTERN = 10'b0000011111;

  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);
  // Two cycles ahead of reload: one for the encoder register, one for holding capture.
  localparam logic [3:0] LREQ_BIT = 4'(WORD_W - 3);

endpackage

// File: rtl/tmds_lane_shifter.sv
// One TMDS data lane: 10-bit shift register, parallel load, LSB-first serial output.
module tmds_lane_shifter
  import tmds_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VAL = CTRL_00
) (
  input  logic              clock_me,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_bit
);

  logic [WORD_W-1:0] r_shreg;

  always_ff @(posedge clock_me or posedge rst) begin
    if (rst) begin
      r_shreg <= RESET_VAL;
    end else if (i_load) begin
      r_shreg <= i_word;
    end else begin
      r_shreg <= {1'b0, r_shreg[WORD_W-1:1]};
    end
  end

  assign o_bit = r_shreg[0];

endmodule

// File: rtl/tmds_serializer.sv
// TMDS bit-clock serializer: holding register, three data lanes, clock lane and encoder pacing.
module tmds_serializer
  import tmds_pkg::*;
#(
  parameter logic [WORD_W-1:0] IDLE_TOKEN = CTRL_00
) (
  input  logic              clock_me,
  input  logic              rst,
  output logic              load_req,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] d0,
  input  logic [WORD_W-1:0] d1,
  input  logic [WORD_W-1:0] d2,
  output logic [3:0]        ser_out,
  output logic              underrun,
  output logic              overrun,
  input  logic              flag_clr
);

  logic [3:0]                   r_bit_cnt;
  logic [3:0]                   w_bit_cnt_d;
  logic                         w_reload;
  logic [2:0][WORD_W-1:0]       r_hold;
  logic                         r_hold_full;
  logic [2:0][WORD_W-1:0]       w_din;
  logic                         r_load_req;
  logic                         r_underrun;
  logic                         r_overrun;
  logic                         w_underrun_set;
  logic                         w_overrun_set;
  logic [2:0]                   w_lane_bit;

  assign w_reload       = (r_bit_cnt == LAST_BIT);
  assign w_bit_cnt_d    = w_reload ? 4'd0 : r_bit_cnt + 4'd1;
  assign w_din          = {d2, d1, d0};
  assign w_underrun_set = w_reload & ~r_hold_full;
  // A reload in the same cycle frees the slot, so that capture is not an overrun.
  assign w_overrun_set  = in_valid & r_hold_full & ~w_reload;

  always_ff @(posedge clock_me or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= 4'd0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_load_req  <= 1'b0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_d;
      r_load_req <= (w_bit_cnt_d == LREQ_BIT);
      if (in_valid) begin
        r_hold      <= w_din;
        r_hold_full <= 1'b1;
      end else if (w_reload) begin
        r_hold_full <= 1'b0;
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (flag_clr) begin
        r_underrun <= 1'b0;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (flag_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_lane
    tmds_lane_shifter #(
      .RESET_VAL (IDLE_TOKEN)
    ) u_lane (
      .clock_me (clock_me),
      .rst      (rst),
      .i_load   (w_reload),
      .i_word   (r_hold_full ? r_hold[i] : IDLE_TOKEN),
      .o_bit    (w_lane_bit[i])
    );
  end

  assign ser_out  = {CLK_PATTERN[r_bit_cnt], w_lane_bit};
  assign load_req = r_load_req;
  assign underrun = r_underrun;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_tmds_serializer.sv
// Scoreboard bench for tmds_serializer: stimulus queues expected words, a monitor checks them.
module tb_tmds_serializer;

  typedef struct packed {
    logic [9:0] l0;
    logic [9:0] l1;
    logic [9:0] l2;
  } exp_t;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] CLKP = 10'b0000011111;
  localparam logic [9:0] LREQ = 10'b0010000000;

  logic       clock_me = 1'b0;
  logic       rst      = 1'b1;
  logic       load_req;
  logic       in_valid = 1'b0;
  logic [9:0] d0 = '0;
  logic [9:0] d1 = '0;
  logic [9:0] d2 = '0;
  logic [3:0] ser_out;
  logic       underrun;
  logic       overrun;
  logic       flag_clr = 1'b0;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ph       = 0;
  logic mon_en   = 1'b0;
  exp_t exp_q[$];

  tmds_serializer dut (
    .clock_me (clock_me),
    .rst      (rst),
    .load_req (load_req),
    .in_valid (in_valid),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .ser_out  (ser_out),
    .underrun (underrun),
    .overrun  (overrun),
    .flag_clr (flag_clr)
  );

  always #5 clock_me = ~clock_me;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // One clock with the given inputs applied at the edge; ph tracks the expected bit_cnt.
  task automatic cyc(input logic v, input logic clr, input logic [9:0] a, input logic [9:0] b,
                     input logic [9:0] c);
    in_valid = v;
    flag_clr = clr;
    d0 = a;
    d1 = b;
    d2 = c;
    @(posedge clock_me);
    #1;
    in_valid = 1'b0;
    flag_clr = 1'b0;
    ph = (ph == 9) ? 0 : ph + 1;
  endtask

  // Monitor: assembles one word per ten bit periods and checks it against the queue head.
  logic [9:0] m_l0, m_l1, m_l2, m_clk, m_lr;
  always @(negedge clock_me) begin
    if (mon_en) begin
      m_l0[ph]  = ser_out[0];
      m_l1[ph]  = ser_out[1];
      m_l2[ph]  = ser_out[2];
      m_clk[ph] = ser_out[3];
      m_lr[ph]  = load_req;
      if (ph == 9) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(m_l0), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("lane0_word", 32'(m_l0), 32'(e.l0));
          chk("lane1_word", 32'(m_l1), 32'(e.l1));
          chk("lane2_word", 32'(m_l2), 32'(e.l2));
        end
        chk("clk_lane", 32'(m_clk), 32'(CLKP));
        chk("load_req_phase", 32'(m_lr), 32'(LREQ));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock_me);
    #1;
    chk("reset_ser_out", 32'(ser_out), 32'h8);
    chk("reset_load_req", 32'(load_req), 32'h0);
    chk("reset_underrun", 32'(underrun), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);

    // Expected words W0..W8: idle x3, nominal x3, overrun result, idle, late-valid word.
    exp_q.push_back('{IDLE, IDLE, IDLE});
    exp_q.push_back('{IDLE, IDLE, IDLE});
    exp_q.push_back('{IDLE, IDLE, IDLE});
    repeat (3) exp_q.push_back('{10'h3FF, 10'h000, 10'h155});
    exp_q.push_back('{10'h002, 10'h000, 10'h000});
    exp_q.push_back('{IDLE, IDLE, IDLE});
    exp_q.push_back('{10'h2AA, 10'h000, 10'h000});

    rst    = 1'b0;
    ph     = 0;
    mon_en = 1'b1;

    // W0/W1: no data; underrun must appear exactly at the 10th clock.
    repeat (9) cyc(1'b0, 1'b0, '0, '0, '0);
    chk("underrun_before_first_reload", 32'(underrun), 32'h0);
    cyc(1'b0, 1'b0, '0, '0, '0);
    chk("underrun_after_first_reload", 32'(underrun), 32'h1);
    repeat (10) cyc(1'b0, 1'b0, '0, '0, '0);

    // W2..W4: nominal pacing, valid at bit_cnt 8; flags cleared at start of W2.
    for (int w = 2; w <= 4; w++) begin
      for (int p = 0; p < 10; p++) begin
        cyc(p == 8, (w == 2) && (p == 0), 10'h3FF, 10'h000, 10'h155);
      end
    end
    chk("underrun_nominal", 32'(underrun), 32'h0);
    chk("overrun_nominal", 32'(overrun), 32'h0);

    // W5: two writes into the holding register before reload.
    for (int p = 0; p < 10; p++) begin
      cyc((p == 3) || (p == 5), 1'b0, (p == 3) ? 10'h001 : 10'h002, '0, '0);
    end
    chk("overrun_set", 32'(overrun), 32'h1);
    chk("underrun_after_overrun", 32'(underrun), 32'h0);

    // W6: clear at ph0; valid coincident with reload plus clear (set must win).
    for (int p = 0; p < 10; p++) begin
      cyc(p == 9, (p == 0) || (p == 9), 10'h2AA, '0, '0);
    end
    chk("underrun_reload_collision", 32'(underrun), 32'h1);
    chk("overrun_cleared", 32'(overrun), 32'h0);

    // W7/W8
    repeat (20) cyc(1'b0, 1'b0, '0, '0, '0);

    // W9: reset mid-word at bit_cnt 4.
    mon_en = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    #1;
    chk("midword_reset_ser_out", 32'(ser_out), 32'h8);
    chk("midword_reset_load_req", 32'(load_req), 32'h0);
    chk("midword_reset_underrun", 32'(underrun), 32'h0);
    chk("midword_reset_overrun", 32'(overrun), 32'h0);
    @(posedge clock_me);
    #1;
    exp_q.push_back('{IDLE, IDLE, IDLE});
    exp_q.push_back('{IDLE, IDLE, IDLE});
    rst    = 1'b0;
    ph     = 0;
    mon_en = 1'b1;
    repeat (20) cyc(1'b0, 1'b0, '0, '0, '0);
    chk("underrun_after_rerun", 32'(underrun), 32'h1);

    mon_en = 1'b0;
    chk("words_outstanding", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
